hvac_actuator_ctrl: RTL

//  Downstream stage of the thermostat controller. Consumes the CurrentTemp and DesiredTemp bytes
//  and drives the Heat, Cool and Fan relay outputs through a mode state machine. The state

---
 rtl/hvac_actuator_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hvac_actuator_ctrl.sv
// HVAC relay sequencer: drives heat/cool/fan relays from temperature compares,
// enforcing deadband, minimum on-time, restart lockout and fan overrun in prescaled ticks.
module hvac_actuator_ctrl #(
    parameter int unsigned TICK_DIV    = 10000000,
    parameter int unsigned HYST        = 1,
    parameter int unsigned MIN_ON      = 30,
    parameter int unsigned MIN_OFF     = 60,
    parameter int unsigned FAN_OVERRUN = 10
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] CurrentTemp,
    input  logic [7:0] DesiredTemp,
    output logic       Heat,
    output logic       Cool,
    output logic       Fan,
    output logic [2:0] Mode,
    output logic       Ready
);

    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned ONW  = (MIN_ON > 0)  ? $clog2(MIN_ON + 1)      : 1;
    localparam int unsigned OFFW = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1)     : 1;
    localparam int unsigned FANW = $clog2(FAN_OVERRUN + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAT = 3'd1,
        ST_COOL = 3'd2,
        ST_FAN  = 3'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [ONW-1:0]    on_cnt_q, on_cnt_d;
    logic [OFFW-1:0]   off_cnt_q, off_cnt_d;
    logic [FANW-1:0]   fan_cnt_q, fan_cnt_d;
    logic              heat_q, heat_d;
    logic              cool_q, cool_d;
    logic              fan_q, fan_d;
    logic              ready_q, ready_d;

    logic              tick_c;
    logic              need_heat_c, need_cool_c, sat_heat_c, sat_cool_c;
    logic              on_done_c, fan_done_c;
    logic              enter_run_c, enter_fan_c;
    logic [8:0]        cur9_c, des9_c;

    // Zero-extended 9-bit compares so setpoint + deadband can never wrap
    assign cur9_c      = {1'b0, CurrentTemp};
    assign des9_c      = {1'b0, DesiredTemp};
    assign need_heat_c = (cur9_c + 9'(HYST)) < des9_c;
    assign need_cool_c = cur9_c > (des9_c + 9'(HYST));
    assign sat_heat_c  = cur9_c >= des9_c;
    assign sat_cool_c  = cur9_c <= des9_c;

    assign tick_c      = (presc_q == PW'(TICK_DIV - 1));
    assign on_done_c   = (on_cnt_q == ONW'(MIN_ON));
    assign fan_done_c  = (fan_cnt_q == FANW'(FAN_OVERRUN));

    // Mode transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Enable && ready_q && need_heat_c)      state_d = ST_HEAT;
                else if (Enable && ready_q && need_cool_c) state_d = ST_COOL;
            end
            ST_HEAT: begin
                if (!Enable)                        state_d = ST_FAN;
                else if (sat_heat_c && on_done_c)   state_d = ST_FAN;
            end
            ST_COOL: begin
                if (!Enable)                        state_d = ST_FAN;
                else if (sat_cool_c && on_done_c)   state_d = ST_FAN;
            end
            ST_FAN: begin
                if (fan_done_c)                     state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_run_c = (state_q == ST_IDLE) && ((state_d == ST_HEAT) || (state_d == ST_COOL));
    assign enter_fan_c = (state_q != ST_FAN) && (state_d == ST_FAN);

    // Tick counters; a clear on state entry takes priority over a coincident tick
    always_comb begin
        presc_d   = tick_c ? '0 : presc_q + PW'(1);
        on_cnt_d  = on_cnt_q;
        off_cnt_d = off_cnt_q;
        fan_cnt_d = fan_cnt_q;
        if (enter_run_c)                        on_cnt_d  = '0;
        else if (tick_c && !on_done_c)          on_cnt_d  = on_cnt_q + ONW'(1);
        if (enter_fan_c)                        off_cnt_d = '0;
        else if (tick_c && (off_cnt_q != OFFW'(MIN_OFF)))
                                                off_cnt_d = off_cnt_q + OFFW'(1);
        if (enter_fan_c)                        fan_cnt_d = '0;
        else if (tick_c && !fan_done_c)         fan_cnt_d = fan_cnt_q + FANW'(1);
    end

    // Relay outputs are flopped decodes of the next state
    always_comb begin
        heat_d  = (state_d == ST_HEAT);
        cool_d  = (state_d == ST_COOL);
        fan_d   = (state_d != ST_IDLE);
        ready_d = (off_cnt_d == OFFW'(MIN_OFF));
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            on_cnt_q  <= '0;
            off_cnt_q <= '0;
            fan_cnt_q <= '0;
            heat_q    <= 1'b0;
            cool_q    <= 1'b0;
            fan_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            on_cnt_q  <= on_cnt_d;
            off_cnt_q <= off_cnt_d;
            fan_cnt_q <= fan_cnt_d;
            heat_q    <= heat_d;
            cool_q    <= cool_d;
            fan_q     <= fan_d;
            ready_q   <= ready_d;
        end
    end

    assign Heat  = heat_q;
    assign Cool  = cool_q;
    assign Fan   = fan_q;
    assign Ready = ready_q;
    assign Mode  = state_q;

endmodule
